// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master for the single-port on-chip RAM: block copy (RAM to RAM)
// or block fill (constant to RAM), one word at a time in ascending order.
module onchip_mem_copy_master #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(1) << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [CW-1:0]     rem_q, rem_d, wdone_d, cnt_in;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d, rdata_q, rdata_d;
    logic [2:0]        wait_q, wait_d;

    logic              cs_d, wr_d, busy_d, done_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    assign avm_clken = 1'b1;
    assign cnt_in    = (word_count > MAX_CNT) ? MAX_CNT : word_count;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wdone_d = words_done;
        mode_d  = mode_q;
        fill_d  = fill_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = cnt_in;
                    mode_d  = mode;
                    fill_d  = fill_data;
                    wdone_d = '0;
                    if (cnt_in == '0) state_d = S_DONE;
                    else if (mode)    state_d = S_WRITE;
                    else              state_d = S_READ;
                end
            end
            S_READ: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 3'(READ_LATENCY - 1)) begin
                    rdata_d = avm_readdata;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_WRITE: begin
                src_d   = src_q + ADDR_W'(1);
                dst_d   = dst_q + ADDR_W'(1);
                wdone_d = words_done + CW'(1);
                rem_d   = rem_q - CW'(1);
                if (rem_q == CW'(1)) state_d = S_DONE;
                else if (mode_q)     state_d = S_WRITE;
                else                 state_d = S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the next state and
    // the post-update pointers to appear during the cycle they belong to.
    always_comb begin
        cs_d    = (state_d == S_READ) || (state_d == S_WRITE);
        wr_d    = (state_d == S_WRITE);
        busy_d  = (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == S_READ)  addr_d = src_d;
        if (state_d == S_WRITE) begin
            addr_d  = dst_d;
            wdata_d = mode_d ? fill_d : rdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            rem_q          <= '0;
            mode_q         <= 1'b0;
            fill_q         <= '0;
            rdata_q        <= '0;
            wait_q         <= '0;
            words_done     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            rem_q          <= rem_d;
            mode_q         <= mode_d;
            fill_q         <= fill_d;
            rdata_q        <= rdata_d;
            wait_q         <= wait_d;
            words_done     <= wdone_d;
            busy           <= busy_d;
            done           <= done_d;
            avm_address    <= addr_d;
            avm_chipselect <= cs_d;
            avm_write      <= wr_d;
            avm_byteenable <= cs_d ? 4'hF : 4'h0;
            avm_writedata  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Bench for onchip_mem_copy_master: RAM model with registered read address,
// scoreboard of expected bus writes, per-scenario timing and readback checks.
module tb_onchip_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  src_addr = '0;
    logic [9:0]  dst_addr = '0;
    logic [10:0] word_count = '0;
    logic [31:0] fill_data = '0;
    logic        busy, done;
    logic [10:0] words_done;
    logic [9:0]  avm_address;
    logic        avm_chipselect, avm_write, avm_clken;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata;

    onchip_mem_copy_master #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .fill_data(fill_data), .busy(busy), .done(done), .words_done(words_done),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // RAM model: registered address, unregistered output, plus a backdoor load port
    logic [31:0] mem [1024];
    logic [9:0]  raddr_q = '0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
        else if (avm_chipselect) raddr_q <= avm_address;
    end
    assign avm_readdata = mem[raddr_q];

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Scoreboard consumer: every bus write must match the next expected one
    always @(negedge clk) begin
        if (reset_n && avm_chipselect && avm_write) begin
            wr_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", avm_address, avm_writedata);
            end else begin
                e = exp_q.pop_front();
                if (avm_address !== e.a || avm_writedata !== e.d || avm_byteenable !== 4'hF)
                    $display("FAIL bus_write: got addr=%h data=%h be=%h, required addr=%h data=%h be=f",
                             avm_address, avm_writedata, avm_byteenable, e.a, e.d);
                else n_pass++;
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic push(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // Leaves the caller #1 after the start edge, i.e. inside cycle 1
    task automatic issue(input logic m, input logic [9:0] s, input logic [9:0] d,
                         input logic [10:0] n, input logic [31:0] f);
        @(posedge clk); #1;
        mode = m; src_addr = s; dst_addr = d; word_count = n; fill_data = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc, output int cs_cnt,
                             output int first_wr, output int last_wr);
        done_cyc = -1; cs_cnt = 0; first_wr = -1; last_wr = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (avm_chipselect) cs_cnt++;
            if (avm_chipselect && avm_write) begin
                if (first_wr < 0) first_wr = i;
                last_wr = i;
            end
            if (done) begin
                done_cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({busy, done, words_done, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b wd=%0d addr=%h cs=%b wr=%b be=%h wdata=%h, required all 0",
                     busy, done, words_done, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata);
        else n_pass++;
        n_checks++;
        if (avm_clken !== 1'b1) $display("FAIL clken_in_reset: got %b, required 1", avm_clken);
        else n_pass++;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_fill;
        int dc, cs, fw, lw;
        for (int i = 0; i < 4; i++) push(10'(10'h3FE + i), 32'hDEADBEEF);
        issue(1'b1, 10'h000, 10'h3FE, 11'd4, 32'hDEADBEEF);
        wait_done(40, dc, cs, fw, lw);
        n_checks++;
        if (dc !== 5 || fw !== 1 || lw !== 4)
            $display("FAIL fill_timing: got done=%0d writes=%0d..%0d, required done=5 writes=1..4", dc, fw, lw);
        else n_pass++;
        n_checks++;
        if (words_done !== 11'd4) $display("FAIL fill_words_done: got %0d, required 4", words_done);
        else n_pass++;
        n_checks++;
        if (mem[10'h3FE] !== 32'hDEADBEEF || mem[10'h3FF] !== 32'hDEADBEEF ||
            mem[10'h000] !== 32'hDEADBEEF || mem[10'h001] !== 32'hDEADBEEF)
            $display("FAIL fill_readback: got %h %h %h %h, required deadbeef x4",
                     mem[10'h3FE], mem[10'h3FF], mem[10'h000], mem[10'h001]);
        else n_pass++;
    endtask

    task automatic test_copy;
        int dc, cs, fw, lw;
        logic [31:0] src [3];
        src[0] = 32'h11111111; src[1] = 32'h22222222; src[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) poke(10'(10'h010 + i), src[i]);
        for (int i = 0; i < 3; i++) push(10'(10'h200 + i), src[i]);
        issue(1'b0, 10'h010, 10'h200, 11'd3, 32'hFFFFFFFF);
        wait_done(60, dc, cs, fw, lw);
        n_checks++;
        if (dc !== 10 || cs !== 6 || fw !== 3 || lw !== 9)
            $display("FAIL copy_timing: got done=%0d cs=%0d writes=%0d..%0d, required done=10 cs=6 writes=3..9",
                     dc, cs, fw, lw);
        else n_pass++;
        n_checks++;
        if (words_done !== 11'd3) $display("FAIL copy_words_done: got %0d, required 3", words_done);
        else n_pass++;
        n_checks++;
        if (mem[10'h200] !== src[0] || mem[10'h201] !== src[1] || mem[10'h202] !== src[2])
            $display("FAIL copy_readback: got %h %h %h, required %h %h %h",
                     mem[10'h200], mem[10'h201], mem[10'h202], src[0], src[1], src[2]);
        else n_pass++;
    endtask

    task automatic test_zero_count;
        int dc, cs, fw, lw;
        issue(1'b0, 10'h005, 10'h006, 11'd0, 32'h0);
        wait_done(20, dc, cs, fw, lw);
        n_checks++;
        if (dc !== 1 || cs !== 0)
            $display("FAIL zero_count: got done=%0d cs_cycles=%0d, required done=1 cs_cycles=0", dc, cs);
        else n_pass++;
        n_checks++;
        if (words_done !== 11'd0) $display("FAIL zero_words_done: got %0d, required 0", words_done);
        else n_pass++;
    endtask

    task automatic test_overlap;
        int dc, cs, fw, lw;
        poke(10'h000, 32'hA5A5A5A5);
        poke(10'h001, 32'h01010101);
        poke(10'h002, 32'h02020202);
        poke(10'h003, 32'h03030303);
        for (int i = 1; i <= 3; i++) push(10'(i), 32'hA5A5A5A5);
        issue(1'b0, 10'h000, 10'h001, 11'd3, 32'h0);
        wait_done(60, dc, cs, fw, lw);
        n_checks++;
        if (mem[1] !== 32'hA5A5A5A5 || mem[2] !== 32'hA5A5A5A5 || mem[3] !== 32'hA5A5A5A5 || dc !== 10)
            $display("FAIL overlap: got %h %h %h done=%0d, required a5a5a5a5 x3 done=10", mem[1], mem[2], mem[3], dc);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int dc = -1;
        int dn = 0;
        for (int i = 0; i < 5; i++) push(10'(10'h100 + i), 32'h12345678);
        issue(1'b1, 10'h000, 10'h100, 11'd5, 32'h12345678);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (done) begin dn++; dc = i; end
            if (i == 2 || i == 3) begin
                start = 1'b1; mode = 1'b0; dst_addr = 10'h050; word_count = 11'd2; fill_data = 32'h0;
            end else begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (dn !== 1 || dc !== 6)
            $display("FAIL ignored_start: got done_pulses=%0d last_done=%0d, required 1 at 6", dn, dc);
        else n_pass++;
        n_checks++;
        if (words_done !== 11'd5 || busy !== 1'b0)
            $display("FAIL ignored_start_state: got words_done=%0d busy=%b, required 5 0", words_done, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int dc, cs, fw, lw;
        for (int i = 0; i < 4; i++) begin
            poke(10'(10'h020 + i), 32'hC0DE0000 + 32'(i));
            poke(10'(10'h300 + i), 32'h0);
        end
        push(10'h300, 32'hC0DE0000);
        push(10'h301, 32'hC0DE0001);
        issue(1'b0, 10'h020, 10'h300, 11'd4, 32'h0);
        repeat (7) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, words_done, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata} !== '0)
            $display("FAIL reset_mid_outputs: got busy=%b cs=%b wr=%b addr=%h wd=%0d, required all 0",
                     busy, avm_chipselect, avm_write, avm_address, words_done);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        n_checks++;
        if (mem[10'h300] !== 32'hC0DE0000 || mem[10'h301] !== 32'hC0DE0001 ||
            mem[10'h302] !== 32'h0 || mem[10'h303] !== 32'h0)
            $display("FAIL reset_mid_mem: got %h %h %h %h, required c0de0000 c0de0001 0 0",
                     mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303]);
        else n_pass++;
        push(10'h302, 32'h77777777);
        push(10'h303, 32'h77777777);
        issue(1'b1, 10'h000, 10'h302, 11'd2, 32'h77777777);
        wait_done(20, dc, cs, fw, lw);
        n_checks++;
        if (dc !== 3 || words_done !== 11'd2 || mem[10'h303] !== 32'h77777777)
            $display("FAIL after_reset_cmd: got done=%0d wd=%0d mem=%h, required 3 2 77777777", dc, words_done, mem[10'h303]);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset;
        test_fill;
        test_copy;
        test_zero_count;
        test_overlap;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onchip_mem_copy_master.md
Name: onchip_mem_copy_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave (10-bit word address, 32-bit data, 4-bit byteenable, chipselect/write, clken, unregistered-output altsyncram).
- Performs block copy (RAM to RAM) or block fill (constant to RAM) on a one-shot start command.
- Reports busy, a done pulse and progress to the controlling logic.
- Sits between processor-side control registers and the memory's s2 port.

Parameters:
- ADDR_W, 10, word-address width of the memory slave.
- DATA_W, 32, data width of the memory slave.
- READ_LATENCY, 1, cycles from the read address cycle until readdata is valid (range 1..4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  first source word address (copy only)
- dst_addr  in  ADDR_W  first destination word address
- word_count  in  ADDR_W+1  number of words, 0..1024
- fill_data  in  DATA_W  fill pattern (fill only)
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle completion pulse
- words_done  out  ADDR_W+1  count of words written in the current/last command
- avm_address  out  ADDR_W  memory address
- avm_chipselect  out  1  memory select
- avm_write  out  1  write strobe (chipselect=1 with write=0 is a read)
- avm_byteenable  out  4  always 4'hF when chipselect=1, else 4'h0
- avm_writedata  out  DATA_W  write data
- avm_clken  out  1  tied 1 (constant, including during reset)
- avm_readdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, all internal pointers, counters and data registers = 0. busy=0, done=0, words_done=0, avm_address=0, avm_chipselect=0, avm_write=0, avm_byteenable=0, avm_writedata=0. Reset mid-command abandons it; no further bus cycles are issued.
- Outputs are registered except avm_clken.
- IDLE: on start=1, latch src, dst, count, mode and fill_data; clear words_done.
  - count=0 -> DONE.
  - mode=1 -> WRITE.
  - mode=0 -> READ.
  - start in any other state is ignored.
- READ (1 cycle): avm_chipselect=1, avm_write=0, avm_address=src_ptr -> WAIT.
- WAIT (READ_LATENCY cycles): avm_chipselect=0. avm_readdata is captured on the clock edge ending the last WAIT cycle -> WRITE.
- WRITE (1 cycle):
  - avm_chipselect=1, avm_write=1, avm_address=dst_ptr.
  - avm_writedata = captured word (copy) or fill_data (fill).
  - At the ending edge: src_ptr++, dst_ptr++, words_done++, remaining--.
  - remaining reaches 0 -> DONE; else READ (copy) or WRITE (fill).
- DONE (1 cycle): done=1, busy=0 -> IDLE. words_done holds its value until the next accepted start.
- Timing:
  - Copy costs 2+READ_LATENCY cycles per word. Fill costs 1 cycle per word, back-to-back writes.
  - Total command time = count*per_word + 1 (DONE) cycles after the start edge.
- Address arithmetic: pointers wrap modulo 2^ADDR_W (0x3FF+1 = 0x000).
- word_count > 1024 is clamped to 1024.
- Overlapping regions: strictly ascending, one word at a time. Each read observes all earlier writes of the same command.

Test Plan:
- Fill: mode=1, dst=0x3FE, count=4, fill_data=0xDEADBEEF -> writes to 0x3FE, 0x3FF, 0x000, 0x001 in cycles 1-4 after the start edge; done=1 in cycle 5; words_done=4; memory readback matches.
- Copy, READ_LATENCY=1: mem[0x010..0x012]=0x11111111/0x22222222/0x33333333; src=0x010, dst=0x200, count=3 -> three READ/WAIT/WRITE triplets; done in cycle 10; mem[0x200..0x202] equals the source words.
- count=0 -> done pulse in cycle 1; avm_chipselect never asserted; words_done=0.
- Overlap: mem[0]=0xA5A5A5A5; src=0, dst=1, count=3 -> mem[1..3]=0xA5A5A5A5.
- Start pulses during busy -> ignored; exactly one done pulse; latched parameters unchanged.
- reset_n low mid-copy after 2 words -> all outputs 0 immediately; only 2 destination words modified; a new start after reset completes normally.
